// File: rtl/ksa_result_if.sv
// Bus bundle between the Kogge-Stone adder, its result stage and the consumer.
// The slave modport is the result stage; the master modport is the
// environment around it (adder on the input side, writeback on the output).
interface ksa_result_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_a_msb;
    logic             in_b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [3:0]       out_flags;

    modport slave (
        input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_sum, out_flags
    );

    modport master (
        output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_sum, out_flags
    );
endinterface

// File: rtl/ksa_result_stage.sv
// Registered result stage behind the 32-bit Kogge-Stone adder.
// Captures sum/carry, derives {V,C,N,Z} at capture time and hands results on
// through a 2-entry skid buffer (main register drives the outputs, skid
// register absorbs one extra entry when the consumer stalls).
// Optional feature: define KSA_RESULT_STICKY_FLAGS_EN to add the sticky
// {V,C} accumulator with its sticky_clr / sticky_vc ports.
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | nothing held, out_valid=0
//   ONE   | main register holds an entry, skid empty
//   FULL  | main and skid both hold entries, in_ready=0
module ksa_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ksa_result_if.slave       bus
`ifdef KSA_RESULT_STICKY_FLAGS_EN
    ,
    input  logic              sticky_clr,
    output logic [1:0]        sticky_vc
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_sum, skid_sum;
    logic [3:0]       main_flags, skid_flags;
    logic [3:0]       in_flags;
    logic             accept, pop;
    logic             load_main_in, load_main_skid, load_skid;

    // Flags of the incoming adder result, ordered {V,C,N,Z}
    always_comb begin
        in_flags    = 4'b0000;
        in_flags[0] = (bus.in_sum == '0);
        in_flags[1] = bus.in_sum[WIDTH-1];
        in_flags[2] = bus.in_cout;
        in_flags[3] = (bus.in_a_msb == bus.in_b_msb) &&
                      (bus.in_sum[WIDTH-1] != bus.in_a_msb);
    end

    assign accept        = bus.in_valid & in_ready_q;
    assign pop           = (state != EMPTY) & bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_sum   = main_sum;
    assign bus.out_flags = main_flags;

    // State register; in_ready is registered from the next state so it never
    // depends combinationally on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    // Next-state and register load selects
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so no accept can coincide with the pop
                if (pop) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Main and skid data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_sum   <= '0;
            main_flags <= '0;
            skid_sum   <= '0;
            skid_flags <= '0;
        end else begin
            if (load_main_in) begin
                main_sum   <= bus.in_sum;
                main_flags <= in_flags;
            end else if (load_main_skid) begin
                main_sum   <= skid_sum;
                main_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_sum   <= bus.in_sum;
                skid_flags <= in_flags;
            end
        end
    end

`ifdef KSA_RESULT_STICKY_FLAGS_EN
    // Sticky {V,C}: clear takes effect before the popped entry is merged in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_vc <= 2'b00;
        end else if (sticky_clr) begin
            sticky_vc <= pop ? main_flags[3:2] : 2'b00;
        end else if (pop) begin
            sticky_vc <= sticky_vc | main_flags[3:2];
        end
    end
`endif

endmodule
